// File: rtl/ham_pkg.sv
// Shared constants and helpers for the shortened (17,12) Hamming code.
// Used by ham_dec and its syndrome sub-module; ham_extract is shared with ham_enc users.
package ham_pkg;
    localparam int HAM_DATA_W = 12;
    localparam int HAM_CW_W   = 17;
    localparam int HAM_SYN_W  = 5;

    localparam int HAM_P1_POS  = 1;
    localparam int HAM_P2_POS  = 2;
    localparam int HAM_P4_POS  = 4;
    localparam int HAM_P8_POS  = 8;
    localparam int HAM_P16_POS = 16;

    // Bit-vector view of the parity positions (bits 0,1,3,7,15).
    localparam logic [HAM_CW_W-1:0] HAM_PARITY_MASK = 17'h0808B;

    // Largest syndrome that still names a bit inside the codeword.
    localparam logic [HAM_SYN_W-1:0] HAM_MAX_SYN = HAM_SYN_W'(HAM_CW_W);

    function automatic logic [HAM_DATA_W-1:0] ham_extract(input logic [HAM_CW_W-1:0] cw);
        return {cw[16], cw[14:8], cw[6:4], cw[2]};
    endfunction

    // Codeword bits covered by syndrome bit k: every position whose index has bit k set.
    function automatic logic [HAM_CW_W-1:0] ham_cover_mask(input int k);
        logic [HAM_CW_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < HAM_CW_W; i++) begin
            mask[i] = (((i + 1) >> k) & 1) != 0;
        end
        return mask;
    endfunction
endpackage

// File: rtl/ham_syndrome.sv
// Combinational syndrome generator for the (17,12) Hamming code.
module ham_syndrome
    import ham_pkg::*;
(
    input  logic [HAM_CW_W-1:0]  codeword,
    output logic [HAM_SYN_W-1:0] syndrome
);
    generate
        for (genvar gi = 0; gi < HAM_SYN_W; gi++) begin : g_syn
            localparam logic [HAM_CW_W-1:0] COVER = ham_cover_mask(gi);
            assign syndrome[gi] = ^(codeword & COVER);
        end
    endgenerate
endmodule

// File: rtl/ham_dec.sv
// Two-stage pipelined (17,12) Hamming decoder with valid/ready on both sides.
// Optional saturating error counters are built only when HAM_DEC_STATS_EN is defined.
module ham_dec
    import ham_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [HAM_CW_W-1:0]   codeword_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [HAM_DATA_W-1:0] data_out,
    output logic [HAM_SYN_W-1:0]  syndrome_out,
    output logic                  err_corr,
    output logic                  err_uncorr,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      cnt_corr,
    output logic [CNT_W-1:0]      cnt_uncorr
);
    logic                 s1_valid_reg;
    logic [HAM_CW_W-1:0]  s1_cw_reg;
    logic [HAM_SYN_W-1:0] s1_syn_reg;
    logic [HAM_SYN_W-1:0] syn_next;
    logic [HAM_CW_W-1:0]  flip_mask;
    logic [HAM_CW_W-1:0]  fixed_cw;
    logic                 corr_next;
    logic                 uncorr_next;
    logic                 s1_adv;
    logic                 s2_adv;

    ham_syndrome u_syndrome (
        .codeword (codeword_in),
        .syndrome (syn_next)
    );

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid_reg || s2_adv;
    assign in_ready = s1_adv;

    // One-hot flip for syndromes 1..17; out-of-range syndromes yield an all-zero mask.
    generate
        for (genvar gi = 0; gi < HAM_CW_W; gi++) begin : g_flip
            assign flip_mask[gi] = (s1_syn_reg == HAM_SYN_W'(gi + 1));
        end
    endgenerate

    assign fixed_cw    = s1_cw_reg ^ flip_mask;
    assign corr_next   = (s1_syn_reg != '0) && (s1_syn_reg <= HAM_MAX_SYN);
    assign uncorr_next = (s1_syn_reg > HAM_MAX_SYN);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_cw_reg    <= '0;
            s1_syn_reg   <= '0;
            out_valid    <= 1'b0;
            data_out     <= '0;
            syndrome_out <= '0;
            err_corr     <= 1'b0;
            err_uncorr   <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_reg <= in_valid;
                s1_cw_reg    <= codeword_in;
                s1_syn_reg   <= syn_next;
            end
            if (s2_adv) begin
                out_valid <= s1_valid_reg;
                if (s1_valid_reg) begin
                    data_out     <= ham_extract(fixed_cw);
                    syndrome_out <= s1_syn_reg;
                    err_corr     <= corr_next;
                    err_uncorr   <= uncorr_next;
                end
            end
        end
    end

`ifdef HAM_DEC_STATS_EN
    logic [CNT_W-1:0] cnt_corr_reg;
    logic [CNT_W-1:0] cnt_uncorr_reg;
    logic             out_fire;

    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt_corr_reg   <= '0;
            cnt_uncorr_reg <= '0;
        end else begin
            if (out_fire && err_corr && (cnt_corr_reg != '1)) begin
                cnt_corr_reg <= cnt_corr_reg + CNT_W'(1);
            end
            if (out_fire && err_uncorr && (cnt_uncorr_reg != '1)) begin
                cnt_uncorr_reg <= cnt_uncorr_reg + CNT_W'(1);
            end
        end
    end

    assign cnt_corr   = cnt_corr_reg;
    assign cnt_uncorr = cnt_uncorr_reg;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign cnt_corr       = '0;
    assign cnt_uncorr     = '0;
`endif
endmodule
